// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU execute-stage sequencer.
//   - ALU op codes (5-bit; bit0 selects the byte variant)
//   - PSW bit positions
//   - sequencer state encoding
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_ADD_B  = 5'b00001;
    localparam logic [4:0] OP_ADDC   = 5'b00010;
    localparam logic [4:0] OP_ADDC_B = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00100;
    localparam logic [4:0] OP_SUB_B  = 5'b00101;
    localparam logic [4:0] OP_SUBC   = 5'b00110;
    localparam logic [4:0] OP_SUBC_B = 5'b00111;
    localparam logic [4:0] OP_DADD   = 5'b01000;
    localparam logic [4:0] OP_DADD_B = 5'b01001;
    localparam logic [4:0] OP_CMP    = 5'b01010;
    localparam logic [4:0] OP_CMP_B  = 5'b01011;
    localparam logic [4:0] OP_AND    = 5'b01100;
    localparam logic [4:0] OP_AND_B  = 5'b01101;
    localparam logic [4:0] OP_BIC    = 5'b01110;
    localparam logic [4:0] OP_BIC_B  = 5'b01111;
    localparam logic [4:0] OP_BIS    = 5'b10000;
    localparam logic [4:0] OP_BIS_B  = 5'b10001;
    localparam logic [4:0] OP_BIT    = 5'b10010;
    localparam logic [4:0] OP_BIT_B  = 5'b10011;
    localparam logic [4:0] OP_XOR    = 5'b10100;
    localparam logic [4:0] OP_XOR_B  = 5'b10101;
    localparam logic [4:0] OP_MOV    = 5'b10110;
    localparam logic [4:0] OP_MOV_B  = 5'b10111;
    localparam logic [4:0] OP_RRA    = 5'b11000;
    localparam logic [4:0] OP_RRA_B  = 5'b11001;
    localparam logic [4:0] OP_RRC    = 5'b11010;
    localparam logic [4:0] OP_RRC_B  = 5'b11011;

    // PSW bit positions
    localparam int PSW_V = 4;
    localparam int PSW_S = 3;
    localparam int PSW_N = 2;
    localparam int PSW_Z = 1;
    localparam int PSW_C = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_op_class.sv
// Op-code classifier for the ALU sequencer.
//   op            : 5-bit ALU op code
//   writes_result : instruction writes its result back to the register file
//   illegal       : op code is in the reserved range 11100-11111
module alu_op_class
    import alu_seq_pkg::*;
(
    input  logic [4:0] op,
    output logic       writes_result,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        illegal       = (op[4:2] == 3'b111);
        writes_result = !illegal;
        // Compare and bit-test only affect the PSW.
        if (op == OP_CMP || op == OP_CMP_B || op == OP_BIT || op == OP_BIT_B) begin
            writes_result = 1'b0;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage controller: accepts one decoded ALU instruction at a time,
// reads operands from the register file, drives the ALU, writes the result
// back and owns the architectural PSW.
//   clk, rst                 : clock, synchronous active-high reset
//   req_*                    : decoded request, valid/ready handshake
//   rf_rd_addr_*/rf_rd_data_*: register-file reads (1-cycle registered data)
//   alu_*                    : combinational ALU interface
//   rf_wr_*                  : register-file write port
//   psw_ld_en/psw_ld_data    : external PSW load, highest priority
//   psw, busy, done, illegal : status
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DW  = 16,
    parameter int RAW = 3,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [4:0]     req_op,
    input  logic [RAW-1:0] req_dst,
    input  logic [RAW-1:0] req_src,
    input  logic           req_rc,
    input  logic [DW-1:0]  req_const,
    input  logic           req_upd,
    output logic [RAW-1:0] rf_rd_addr_a,
    output logic [RAW-1:0] rf_rd_addr_b,
    input  logic [DW-1:0]  rf_rd_data_a,
    input  logic [DW-1:0]  rf_rd_data_b,
    output logic [DW-1:0]  alu_op1,
    output logic [DW-1:0]  alu_op2,
    output logic [OPW-1:0] alu_instr,
    output logic           alu_opt,
    output logic [DW-1:0]  alu_psw_i,
    input  logic [DW-1:0]  alu_result,
    input  logic [DW-1:0]  alu_psw_o,
    output logic           rf_wr_en,
    output logic [RAW-1:0] rf_wr_addr,
    output logic [DW-1:0]  rf_wr_data,
    input  logic           psw_ld_en,
    input  logic [DW-1:0]  psw_ld_data,
    output logic [DW-1:0]  psw,
    output logic           busy,
    output logic           done,
    output logic           illegal
);

    state_e         state_q, state_d;
    logic [4:0]     op_q, op_d;
    logic [RAW-1:0] dst_q, dst_d;
    logic [RAW-1:0] src_q, src_d;
    logic           rc_q, rc_d;
    logic           upd_q, upd_d;
    logic [DW-1:0]  const_q, const_d;
    logic [DW-1:0]  res_q, res_d;
    logic [DW-1:0]  cpsw_q, cpsw_d;
    logic [DW-1:0]  psw_q, psw_d;

    logic writes_result;
    logic op_illegal;

    alu_op_class u_op_class (
        .op            (op_q),
        .writes_result (writes_result),
        .illegal       (op_illegal)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        rc_d    = rc_q;
        upd_d   = upd_q;
        const_d = const_q;
        res_d   = res_q;
        cpsw_d  = cpsw_q;
        psw_d   = psw_q;

        unique case (state_q)
            IDLE: begin
                // req_ready is high exactly in IDLE, so req_valid alone means a transfer.
                if (req_valid) begin
                    op_d    = req_op;
                    dst_d   = req_dst;
                    src_d   = req_src;
                    rc_d    = req_rc;
                    upd_d   = req_upd;
                    const_d = req_const;
                    state_d = READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                res_d   = alu_result;
                cpsw_d  = alu_psw_o;
                state_d = WB;
            end
            WB: begin
                // Loaded even without req_upd: the ALU already preserves flags it must not touch.
                if (!op_illegal) psw_d = cpsw_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (psw_ld_en) psw_d = psw_ld_data;
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset; an abort mid-instruction simply returns to IDLE before WB.
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            rc_q    <= 1'b0;
            upd_q   <= 1'b0;
            const_q <= '0;
            res_q   <= '0;
            cpsw_q  <= '0;
            psw_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            rc_q    <= rc_d;
            upd_q   <= upd_d;
            const_q <= const_d;
            res_q   <= res_d;
            cpsw_q  <= cpsw_d;
            psw_q   <= psw_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == WB);
    assign illegal      = (state_q == WB) && op_illegal;

    assign rf_rd_addr_a = dst_q;
    assign rf_rd_addr_b = src_q;

    // Read data arrives one cycle after READ, so the operands are valid throughout EXEC.
    assign alu_op1      = rf_rd_data_a;
    assign alu_op2      = rc_q ? const_q : rf_rd_data_b;
    assign alu_instr    = {{(OPW-5){1'b0}}, op_q};
    assign alu_opt      = upd_q;
    assign alu_psw_i    = psw_q;

    assign rf_wr_en     = (state_q == WB) && writes_result;
    assign rf_wr_addr   = dst_q;
    assign rf_wr_data   = res_q;
    assign psw          = psw_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [2:0]  req_dst, req_src;
    logic        req_rc;
    logic [15:0] req_const;
    logic        req_upd;
    logic [2:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [15:0] rf_rd_data_a, rf_rd_data_b;
    logic [15:0] alu_op1, alu_op2;
    logic [5:0]  alu_instr;
    logic        alu_opt;
    logic [15:0] alu_psw_i, alu_result, alu_psw_o;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        psw_ld_en;
    logic [15:0] psw_ld_data;
    logic [15:0] psw;
    logic        busy, done, illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_dst(req_dst), .req_src(req_src), .req_rc(req_rc),
        .req_const(req_const), .req_upd(req_upd),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instr(alu_instr),
        .alu_opt(alu_opt), .alu_psw_i(alu_psw_i), .alu_result(alu_result),
        .alu_psw_o(alu_psw_o), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .psw_ld_en(psw_ld_en), .psw_ld_data(psw_ld_data),
        .psw(psw), .busy(busy), .done(done), .illegal(illegal)
    );

    // Register file with registered reads and a bench-side preload port.
    logic [15:0] rf [8];
    logic        tb_wr_en = 1'b0;
    logic [2:0]  tb_wr_addr = '0;
    logic [15:0] tb_wr_data = '0;

    always @(posedge clk) begin
        rf_rd_data_a <= rf[rf_rd_addr_a];
        rf_rd_data_b <= rf[rf_rd_addr_b];
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
        else if (tb_wr_en) rf[tb_wr_addr] <= tb_wr_data;
    end

    // ALU model: add, addc, cmp; anything else returns recognisable garbage.
    logic [16:0] sum;
    logic [15:0] b_eff;
    logic        known;
    always_comb begin
        sum   = '0;
        b_eff = alu_op2;
        known = 1'b1;
        case (alu_instr[4:0])
            5'b00000: sum = {1'b0, alu_op1} + {1'b0, alu_op2};
            5'b00010: sum = {1'b0, alu_op1} + {1'b0, alu_op2} + {16'd0, alu_psw_i[0]};
            5'b01010: begin
                b_eff = ~alu_op2;
                sum   = {1'b0, alu_op1} + {1'b0, ~alu_op2} + 17'd1;
            end
            default: known = 1'b0;
        endcase
        alu_result = known ? sum[15:0] : 16'hDEAD;
        alu_psw_o  = alu_psw_i;
        if (!known) begin
            alu_psw_o = 16'hFFFF;
        end else if (alu_opt) begin
            alu_psw_o[0] = sum[16];
            alu_psw_o[1] = (sum[15:0] == 16'h0000);
            alu_psw_o[2] = sum[15];
            alu_psw_o[4] = (alu_op1[15] == b_eff[15]) && (sum[15] != alu_op1[15]);
        end
    end

    // Values observed by issue()
    int          lat, wr_cnt;
    logic        ill_at_done, done_after;
    logic [15:0] ex_op1, ex_op2;
    logic [2:0]  rd_a_seen, rd_b_seen;

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_data = d;
        @(negedge clk);
        tb_wr_en = 1'b0;
    endtask

    task automatic drive_req(input logic [4:0] op, input logic [2:0] dst, input logic [2:0] src,
                             input logic rc, input logic [15:0] k, input logic upd);
        req_op = op; req_dst = dst; req_src = src; req_rc = rc; req_const = k; req_upd = upd;
    endtask

    // Issues one request and follows it to completion (bounded).
    task automatic issue(input logic [4:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic rc, input logic [15:0] k, input logic upd);
        @(negedge clk);
        drive_req(op, dst, src, rc, k, upd);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; wr_cnt = rf_wr_en ? 1 : 0;
        rd_a_seen = rf_rd_addr_a; rd_b_seen = rf_rd_addr_b;
        ex_op1 = 'x; ex_op2 = 'x;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (rf_wr_en) wr_cnt++;
            if (lat == 2) begin ex_op1 = alu_op1; ex_op2 = alu_op2; end
        end
        ill_at_done = illegal;
        @(negedge clk);
        if (rf_wr_en) wr_cnt++;
        done_after = done;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; psw_ld_en = 1'b0; psw_ld_data = '0;
        drive_req(5'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if ({busy, done, illegal, rf_wr_en} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp 0000", {busy, done, illegal, rf_wr_en}); end
        checks++; if (psw !== 16'h0000) begin errors++; $display("FAIL reset_psw got %h exp 0000", psw); end
        checks++; if ({alu_instr, alu_opt, rf_wr_data} !== 23'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", {alu_instr, alu_opt, rf_wr_data}); end
    endtask

    task automatic test_add_reg;
        issue(5'b00000, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d exp 3", lat); end
        checks++; if ({rd_a_seen, rd_b_seen} !== {3'd1, 3'd2}) begin errors++; $display("FAIL add_rd_addr got %h exp %h", {rd_a_seen, rd_b_seen}, {3'd1, 3'd2}); end
        checks++; if ({ex_op1, ex_op2} !== {16'h0005, 16'h0003}) begin errors++; $display("FAIL add_operands got %h exp 00050003", {ex_op1, ex_op2}); end
        checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL add_wr_pulses got %0d exp 1", wr_cnt); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b exp 0", done_after); end
        checks++; if (rf[1] !== 16'h0008) begin errors++; $display("FAIL add_r1 got %h exp 0008", rf[1]); end
        checks++; if (psw !== 16'h0000) begin errors++; $display("FAIL add_psw got %h exp 0000", psw); end
    endtask

    task automatic test_add_const_overflow;
        preload(3'd1, 16'h7FFF);
        issue(5'b00000, 3'd1, 3'd7, 1'b1, 16'h0001, 1'b1);
        checks++; if (ex_op2 !== 16'h0001) begin errors++; $display("FAIL ovf_op2 got %h exp 0001", ex_op2); end
        checks++; if (rf[1] !== 16'h8000) begin errors++; $display("FAIL ovf_r1 got %h exp 8000", rf[1]); end
        checks++; if (psw !== 16'h0014) begin errors++; $display("FAIL ovf_psw got %h exp 0014", psw); end
    endtask

    task automatic test_cmp;
        issue(5'b01010, 3'd3, 3'd0, 1'b1, 16'h0004, 1'b1);
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL cmp_wr_pulses got %0d exp 0", wr_cnt); end
        checks++; if (rf[3] !== 16'h0004) begin errors++; $display("FAIL cmp_r3 got %h exp 0004", rf[3]); end
        checks++; if (psw !== 16'h0003) begin errors++; $display("FAIL cmp_psw got %h exp 0003", psw); end
    endtask

    task automatic test_illegal;
        issue(5'b11110, 3'd4, 3'd5, 1'b0, 16'h0, 1'b1);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ill_latency got %0d exp 3", lat); end
        checks++; if (ill_at_done !== 1'b1) begin errors++; $display("FAIL ill_pulse got %b exp 1", ill_at_done); end
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL ill_wr_pulses got %0d exp 0", wr_cnt); end
        checks++; if (psw !== 16'h0003) begin errors++; $display("FAIL ill_psw got %h exp 0003", psw); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_after got %b exp 0", illegal); end
    endtask

    task automatic test_psw_load_priority;
        // psw C=1 from cmp, so addc gives 0x10 + 0x20 + 1.
        @(negedge clk);
        drive_req(5'b00010, 3'd4, 3'd5, 1'b0, 16'h0, 1'b1);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({done, rf_wr_en} !== 2'b11) begin errors++; $display("FAIL addc_wb got %b exp 11", {done, rf_wr_en}); end
        psw_ld_en = 1'b1; psw_ld_data = 16'h0001;
        @(negedge clk);
        psw_ld_en = 1'b0;
        checks++; if (psw !== 16'h0001) begin errors++; $display("FAIL addc_psw got %h exp 0001", psw); end
        checks++; if (rf[4] !== 16'h0031) begin errors++; $display("FAIL addc_r4 got %h exp 0031", rf[4]); end
    endtask

    task automatic test_reset_abort;
        int wr_seen = 0;
        @(negedge clk);
        drive_req(5'b00000, 3'd6, 3'd6, 1'b0, 16'h0, 1'b1);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (rf_wr_en) wr_seen++;
        checks++; if ({busy, req_ready, done} !== 3'b010) begin errors++; $display("FAIL abort_state got %b exp 010", {busy, req_ready, done}); end
        checks++; if (psw !== 16'h0000) begin errors++; $display("FAIL abort_psw got %h exp 0000", psw); end
        repeat (3) begin
            @(negedge clk);
            if (rf_wr_en) wr_seen++;
        end
        checks++; if (wr_seen !== 0) begin errors++; $display("FAIL abort_wr got %0d exp 0", wr_seen); end
        checks++; if (rf[6] !== 16'h0100) begin errors++; $display("FAIL abort_r6 got %h exp 0100", rf[6]); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        @(negedge clk);
        drive_req(5'b00000, 3'd5, 3'd0, 1'b1, 16'h0001, 1'b0);
        req_valid = 1'b1;
        @(negedge clk);
        // First request is latched; present the second one and keep valid high.
        drive_req(5'b00000, 3'd2, 3'd0, 1'b1, 16'h0002, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c%0d got %b exp 0", c, req_ready); end
            if (c == 3) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", done); end
            end
            @(negedge clk);
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t4 got %b exp 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_latency2 got %0d exp 3", n); end
        @(negedge clk);
        checks++; if ({rf[5], rf[2]} !== {16'h0021, 16'h0005}) begin errors++; $display("FAIL b2b_regs got %h exp 00210005", {rf[5], rf[2]}); end
        checks++; if (psw !== 16'h0000) begin errors++; $display("FAIL b2b_psw got %h exp 0000", psw); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        test_reset;
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        preload(3'd3, 16'h0004);
        preload(3'd4, 16'h0010);
        preload(3'd5, 16'h0020);
        preload(3'd6, 16'h0100);
        test_add_reg;
        test_add_const_overflow;
        test_cmp;
        test_illegal;
        test_psw_load_priority;
        test_reset_abort;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execute-stage controller that sequences the combinational ALU for one register-to-register or constant-to-register instruction at a time.
- Accepts a decoded request over a valid/ready handshake, reads operands from the register file, drives the ALU, captures its result, writes back, and owns the architectural PSW register.
- Sits between the instruction decoder and the register file / ALU pair.

Parameters:
- DW, 16, datapath and PSW width
- RAW, 3, register-file address width (R0-R7)
- OPW, 6, ALU instruction field width; op codes occupy [4:0], [5] driven 0

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  5  ALU op code; bit0 = byte (.b) variant
- req_dst  input  RAW  destination register, also ALU op1
- req_src  input  RAW  source register, ALU op2 when req_rc=0
- req_rc  input  1  1 = op2 comes from req_const
- req_const  input  DW  constant operand
- req_upd  input  1  PSW-update enable, drives alu_opt
- rf_rd_addr_a  output  RAW  register-file read address, dst
- rf_rd_addr_b  output  RAW  register-file read address, src
- rf_rd_data_a  input  DW  read data; registered, 1-cycle latency
- rf_rd_data_b  input  DW  read data; registered, 1-cycle latency
- alu_op1  output  DW  ALU operand 1
- alu_op2  output  DW  ALU operand 2
- alu_instr  output  OPW  ALU op code
- alu_opt  output  1  ALU PSW-update enable
- alu_psw_i  output  DW  PSW presented to the ALU
- alu_result  input  DW  ALU result, combinational
- alu_psw_o  input  DW  ALU next PSW, combinational
- rf_wr_en  output  1  register write strobe
- rf_wr_addr  output  RAW  register write address
- rf_wr_data  output  DW  register write data
- psw_ld_en  input  1  external PSW load (exception/return path)
- psw_ld_data  input  DW  external PSW value
- psw  output  DW  architectural PSW (V=4, S=3, N=2, Z=1, C=0)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at instruction completion
- illegal  output  1  one-cycle pulse with done for reserved op codes

Behaviour:
- Reset: state=IDLE; psw=0; req_ready=1; busy, done, illegal, rf_wr_en=0; every registered operand, op-code and result field=0. Reset mid-instruction aborts with no register write.
- Request handshake: a transfer occurs when req_valid and req_ready are both high. req_ready=1 only in IDLE. All req_* fields latch on acceptance.
- FSM:
  - IDLE: on transfer go to READ.
  - READ: rf_rd_addr_a and rf_rd_addr_b driven from the latched fields; next cycle go to EXEC.
  - EXEC: alu_op1=rf_rd_data_a (registered). alu_op2=req_rc?const:rf_rd_data_b. ALU inputs stay stable for the whole cycle. alu_result and alu_psw_o are captured at the cycle end; go to WB.
  - WB: rf_wr_en=writes_result; psw<=captured PSW; done=1; go to IDLE.
- Latency: transfer at cycle T -> done at T+3. Throughput is one instruction per 4 cycles; the next transfer is possible at T+4.
- alu_psw_i=psw at all times. alu_instr and alu_opt are held from the latched request while busy.
- writes_result=0 for cmp/cmp.b (01010/01011) and bit/bit.b (10010/10011). These update PSW only.
- The captured PSW is loaded in WB even when req_upd=0, because the ALU itself preserves flags, and shifts and dadd may alter C.
- Illegal op codes 11100-11111: no register write, psw unchanged, illegal=1 together with done.
- psw_ld_en: loads psw in any state. If it coincides with WB, the external load wins.
- dst==src and req_rc with req_src=dst are legal; no special casing.
- req_valid dropped while busy is ignored; the request is already latched.

Decomposition:
- Package alu_seq_pkg:
  - op-code localparams (ADD..RRC_B)
  - PSW bit indices V/S/N/Z/C
  - state enum IDLE/READ/EXEC/WB
- One sub-module, alu_op_class: combinational; maps op code to writes_result and illegal.

Test Plan:
- R1=0x0005, R2=0x0003, add (00000) dst=R1 src=R2 upd=1 -> done at T+3, R1=0x0008, psw=0x0000, rf_wr_en exactly one cycle.
- R1=0x7FFF, const=0x0001, rc=1, add upd=1 -> R1=0x8000, psw V=1, N=1, C=0 (0x0014).
- R3=0x0004, cmp with const 0x0004 -> rf_wr_en never asserted, R3 unchanged, psw Z=1.
- Op 11110 with req_valid -> done and illegal pulse together, no write, psw unchanged.
- addc issued with psw_ld_en=1, psw_ld_data=0x0001 asserted on the WB cycle -> psw=0x0001 (external wins), R write still occurs.
- rst asserted in EXEC -> next cycle IDLE, req_ready=1, no rf_wr_en. A back-to-back request with req_valid held high is accepted only at T+4.
